// File: rtl/prog_loader.sv
// Streaming program loader: assembles IN_WIDTH beats into INSTR_WIDTH words and
// writes them to auto-incrementing addresses of one core or all cores.
module prog_loader #(
   parameter int CORES       = 8,
   parameter int LOG_CORES   = 3,
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 32,
   parameter int IN_WIDTH    = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [LOG_CORES-1:0]           sel,
   input  logic                           broadcast,
   input  logic [PC_WIDTH-1:0]            base_addr,
   input  logic [PC_WIDTH:0]              count,
   input  logic                           abort,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [IN_WIDTH-1:0]            in_data,
   output logic                           busy,
   output logic                           done,
   output logic [CORES-1:0]               cwe,
   output logic [CORES*PC_WIDTH-1:0]      cwaddr,
   output logic [CORES*INSTR_WIDTH-1:0]   cwdata
);

   localparam int BEATS = INSTR_WIDTH / IN_WIDTH;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

   typedef enum logic {IDLE, LOAD} state_t;

   state_t                       state_q, state_d;
   logic [LOG_CORES-1:0]         sel_q, sel_d;
   logic                         bcast_q, bcast_d;
   logic [PC_WIDTH-1:0]          addr_q, addr_d;
   logic [PC_WIDTH:0]            rem_q, rem_d;
   logic [BW-1:0]                beat_q, beat_d;
   logic [INSTR_WIDTH-1:0]       word_q, word_d, word_nx;
   logic [CORES-1:0]             mask;
   logic [CORES-1:0]             cwe_q, cwe_d;
   logic [CORES*PC_WIDTH-1:0]    cwaddr_q, cwaddr_d;
   logic [CORES*INSTR_WIDTH-1:0] cwdata_q, cwdata_d;
   logic                         done_q, done_d;
   logic                         accept;

   assign in_ready = (state_q == LOAD) && !abort;
   assign busy     = (state_q == LOAD);
   assign accept   = in_valid && in_ready;
   assign done     = done_q;
   assign cwe      = cwe_q;
   assign cwaddr   = cwaddr_q;
   assign cwdata   = cwdata_q;

   // A sel beyond the core range matches no bit, so the word is consumed unwritten.
   always_comb begin
      mask = '0;
      if (bcast_q) begin
         mask = '1;
      end else begin
         for (int unsigned c = 0; c < CORES; c++) begin
            if (32'(sel_q) == c) mask[c] = 1'b1;
         end
      end
   end

   always_comb begin
      word_nx = word_q;
      for (int unsigned k = 0; k < BEATS; k++) begin
         if (beat_q == BW'(k)) word_nx[k*IN_WIDTH +: IN_WIDTH] = in_data;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      bcast_d  = bcast_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      beat_d   = beat_q;
      word_d   = word_q;
      cwe_d    = '0;
      cwaddr_d = '0;
      cwdata_d = '0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               if (count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = LOAD;
                  sel_d   = sel;
                  bcast_d = broadcast;
                  addr_d  = base_addr;
                  rem_d   = count;
                  beat_d  = '0;
                  word_d  = '0;
               end
            end
         end
         LOAD: begin
            if (abort) begin
               state_d = IDLE;
               rem_d   = '0;
               beat_d  = '0;
               word_d  = '0;
            end else if (accept) begin
               word_d = word_nx;
               if (beat_q == LAST) begin
                  beat_d = '0;
                  cwe_d  = mask;
                  for (int unsigned c = 0; c < CORES; c++) begin
                     if (mask[c]) begin
                        cwaddr_d[c*PC_WIDTH +: PC_WIDTH]       = addr_q;
                        cwdata_d[c*INSTR_WIDTH +: INSTR_WIDTH] = word_nx;
                     end
                  end
                  addr_d = addr_q + PC_WIDTH'(1);
                  rem_d  = rem_q - (PC_WIDTH+1)'(1);
                  if (rem_q == (PC_WIDTH+1)'(1)) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         bcast_q  <= 1'b0;
         addr_q   <= '0;
         rem_q    <= '0;
         beat_q   <= '0;
         word_q   <= '0;
         cwe_q    <= '0;
         cwaddr_q <= '0;
         cwdata_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         bcast_q  <= bcast_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         beat_q   <= beat_d;
         word_q   <= word_d;
         cwe_q    <= cwe_d;
         cwaddr_q <= cwaddr_d;
         cwdata_q <= cwdata_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Sequential, streaming successor to the combinational programming multiplexer. It accepts a narrow valid/ready stream of program bytes and assembles each group of beats into an INSTR_WIDTH instruction. Each assembled instruction is written to consecutive, auto-incrementing addresses of one selected core, or of all cores in broadcast mode. It sits between the external programming interface and the per-core instruction memories, driving their write ports directly.

## Interface
Parameters:
- CORES, 8, number of cores
- LOG_CORES, 3, width of core select
- PC_WIDTH, 8, instruction-memory address width
- INSTR_WIDTH, 32, instruction width; must be an integer multiple of IN_WIDTH
- IN_WIDTH, 8, stream beat width; BEATS = INSTR_WIDTH/IN_WIDTH (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a load; sampled only in IDLE
- sel  in  LOG_CORES  target core, latched at start
- broadcast  in  1  write all cores, latched at start
- base_addr  in  PC_WIDTH  first write address, latched at start
- count  in  PC_WIDTH+1  number of instructions, latched at start
- abort  in  1  cancel the load in progress
- in_valid  in  1  stream beat valid
- in_ready  out  1  stream beat ready
- in_data  in  IN_WIDTH  stream beat
- busy  out  1  high while in LOAD
- done  out  1  one-cycle pulse on normal completion
- cwe  out  CORES  per-core write enable
- cwaddr  out  CORES*PC_WIDTH  per-core address; slice c at [c*PC_WIDTH +: PC_WIDTH]
- cwdata  out  CORES*INSTR_WIDTH  per-core data; slice c at [c*INSTR_WIDTH +: INSTR_WIDTH]

## Operation
- States: IDLE and LOAD.
- IDLE to LOAD: start=1, abort=0, count≠0.
  - Latch sel, broadcast, base_addr into the address register, and count into the remaining counter.
  - Clear the beat counter.
- IDLE with start=1 and count=0: stay IDLE, pulse done, no writes.
- start is ignored in LOAD. abort in IDLE has no effect and takes priority over start.
- in_ready = (state==LOAD) && !abort, combinational.
- Beat accepted when in_valid && in_ready.
  - Beat k of a word (k = 0..BEATS-1) fills bits [k*IN_WIDTH +: IN_WIDTH], little-endian, first beat lowest.
- Word completion, on acceptance of beat BEATS-1:
  - Register a write: target mask = all ones if broadcast, else one-hot(sel). Bits ≥ CORES are dropped, so a sel ≥ CORES writes nothing but still consumes the stream.
  - Address: increment by 1, wrapping modulo 2^PC_WIDTH.
  - Remaining counter: decrement by 1. If it reaches 0, go to IDLE and pulse done.
- Write outputs:
  - Driven from registers.
  - Targeted slices carry the address and data; all non-targeted slices and cwe bits are forced to zero.
  - All write outputs are zero in every cycle without a write.
- abort in LOAD: go to IDLE and discard the partial word and the remaining count. No done, no write.
- busy = (state==LOAD).

## Timing
- Reset (rst_n low, asynchronous): state IDLE; in_ready, busy, done, cwe, cwaddr, cwdata all 0; internal counters 0. Reset mid-word discards everything.
- start sampled at edge T: busy and in_ready are high from T+1.
- Final beat of a word accepted at edge E:
  - cwe/cwaddr/cwdata are valid for exactly the cycle E+1.
  - in_ready may stay high in cycle E+1, so back-to-back words are possible.
  - With BEATS=1, one write per cycle is possible.
- Final word of the load:
  - done=1 in cycle E+1, coincident with the last cwe.
  - busy and in_ready are 0 from E+1.
- count=0 start at edge T: done=1 in cycle T+1; busy and in_ready never go high.
- abort high in a LOAD cycle: no beat is accepted that cycle. At the next edge the state is IDLE.
- in_valid gaps: stall without state change. Latency is measured only in accepted beats.

## Test plan
All scenarios use CORES=8, PC_WIDTH=8, INSTR_WIDTH=32, IN_WIDTH=8.
- Single-core load:
  - Stimulus: sel=3, base_addr=0x10, count=2; bytes 0x11..0x88 streamed continuously.
  - Required: cwe=0x08 for one cycle with slice 3 = (0x10, 0x44332211), then cwe=0x08 with (0x11, 0x88776655).
  - Required: done coincident with the second write; all other slices 0 throughout.
- Broadcast with wrap:
  - Stimulus: broadcast=1, base_addr=0xFF, count=2.
  - Required: cwe=0xFF with every slice at address 0xFF, then 0x00; data identical in every slice.
- Stalls:
  - Stimulus: scenario 1 with in_valid toggling pseudo-randomly.
  - Required: identical writes; no write while fewer than 4 beats have been accepted since the previous write.
- Abort:
  - Stimulus: abort one cycle after 2 beats of word 0.
  - Required: no cwe, no done; busy=0 the next cycle.
  - Required: a follow-up load with sel=0, base_addr=0x00, count=1, bytes 0x01..0x04 writes 0x04030201 at 0x00, proving the beat counter was cleared.
- count=0:
  - Required: done pulses in the cycle after start; busy, in_ready and cwe stay 0.
- Reset mid-word:
  - Stimulus: drop rst_n after 3 beats.
  - Required: all outputs 0 immediately; after release, a fresh load produces correct data with no leftover bytes.
